// File: rtl/steer_sense_sched.sv
// steer_sense_sched: round-robin A2D sequencer, rider flags and balance timer.
// FAST_SIM_EN: 15-bit timer and conversion period forced to 64 clocks.
module steer_sense_sched #(
    parameter int          PERIOD       = 2048,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] HYST         = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        pair_vld,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16,
    input  logic        clr_tmr,
    output logic        tmr_full
);

`ifdef FAST_SIM_EN
    localparam int EFF_PERIOD = 64;
    localparam int TMR_W      = 15;
`else
    localparam int EFF_PERIOD = PERIOD;
    localparam int TMR_W      = 26;
`endif
    localparam int CNT_W = $clog2(EFF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EFF_PERIOD - 1);
    localparam logic [12:0] HI_THR = {1'b0, MIN_RIDER_WT} + {1'b0, HYST};
    localparam logic [12:0] LO_THR = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};

    typedef enum logic [2:0] {
        IDLE, CMD, WAIT1, GAP, READ, WAIT2
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] per_cnt;
    logic             pending;
    logic             pair_pend;
    logic [TMR_W-1:0] tmr;
    logic             tick;
    logic             consume;
    logic [2:0]       ch;
    logic [15:0]      ch_word;
    logic [12:0]      sum;
    logic [12:0]      diff;
    logic [12:0]      thr_1516;
    logic             unused_rd;

    assign unused_rd = &{1'b0, spi_rd[15:12]};
    assign tick      = (per_cnt == CNT_MAX);
    assign consume   = (state == IDLE) && pending;

    always_comb begin
        ch = 3'd0;
        unique case (idx)
            2'd0: ch = 3'd0;
            2'd1: ch = 3'd4;
            2'd2: ch = 3'd5;
            2'd3: ch = 3'd6;
        endcase
    end

    assign ch_word = {2'b00, ch, 11'h000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            pending <= 1'b0;
        end else begin
            per_cnt <= tick ? '0 : per_cnt + CNT_W'(1);
            // a tick while a request is already queued is dropped
            if (consume)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spi_wrt   <= 1'b0;
            spi_cmd   <= 16'h0000;
            idx       <= 2'd0;
            pair_pend <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            spi_wrt   <= 1'b0;
            pair_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        state   <= CMD;
                        spi_wrt <= 1'b1;
                        spi_cmd <= ch_word;
                    end
                end
                CMD:   state <= WAIT1;
                WAIT1: if (spi_done) state <= GAP;
                GAP: begin
                    state   <= READ;
                    spi_wrt <= 1'b1;
                    spi_cmd <= ch_word;
                end
                READ:  state <= WAIT2;
                WAIT2: begin
                    if (spi_done) begin
                        state     <= IDLE;
                        idx       <= idx + 2'd1;
                        pair_pend <= (idx == 2'd1);
                        unique case (idx)
                            2'd0: lft_ld    <= spi_rd[11:0];
                            2'd1: rght_ld   <= spi_rd[11:0];
                            2'd2: steer_pot <= spi_rd[11:0];
                            2'd3: batt      <= spi_rd[11:0];
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff     = (lft_ld >= rght_ld) ? {1'b0, lft_ld - rght_ld}
                                          : {1'b0, rght_ld - lft_ld};
    assign thr_1516 = sum - (sum >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_vld      <= 1'b0;
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b1;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else begin
            pair_vld <= pair_pend;
            if (pair_pend) begin
                sum_gt_min    <= (sum > HI_THR);
                sum_lt_min    <= (sum < LO_THR);
                diff_gt_1_4   <= (diff > (sum >> 2));
                diff_gt_15_16 <= (diff > thr_1516);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (clr_tmr)
            tmr <= '0;
        else if (!(&tmr))
            tmr <= tmr + TMR_W'(1);
    end

    assign tmr_full = &tmr;

endmodule

// File: tb/tb_steer_sense_sched.sv
// Bench for steer_sense_sched: SPI responder, timing/flag reference model.
module tb_steer_sense_sched;
    localparam int P = 64;

    logic        clk;
    logic        rst_n;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        pair_vld;
    logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
    logic        clr_tmr;
    logic        tmr_full;

    steer_sense_sched #(.PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rd(spi_rd),
        .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt),
        .pair_vld(pair_vld),
        .sum_gt_min(sum_gt_min), .sum_lt_min(sum_lt_min),
        .diff_gt_1_4(diff_gt_1_4), .diff_gt_15_16(diff_gt_15_16),
        .clr_tmr(clr_tmr), .tmr_full(tmr_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] cmd_word(input int i);
        logic [2:0] c;
        case (i)
            0: c = 3'd0;
            1: c = 3'd4;
            2: c = 3'd5;
            default: c = 3'd6;
        endcase
        return {2'b00, c, 11'h000};
    endfunction

    // {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}
    function automatic logic [3:0] flag_model(input logic [11:0] l,
                                              input logic [11:0] r);
        int s, d;
        s = int'(l) + int'(r);
        d = (l > r) ? int'(l) - int'(r) : int'(r) - int'(l);
        return {s > 576, s < 448, d > s / 4, d > s - s / 16};
    endfunction

    function automatic logic [11:0] get_res(input int i);
        case (i)
            0: return lft_ld;
            1: return rght_ld;
            2: return steer_pot;
            default: return batt;
        endcase
    endfunction

    int          ecnt = 0;
    int          lat = 5;
    logic [11:0] data_q[$];
    logic [15:0] cmd_log[$];
    logic [11:0] exp_res[4];
    int          exp_idx = 0, wr_in_conv = 0, cnt_down = 0;
    bit          busy = 0, rd_phase = 0, wr_exp = 1, chk_pend = 0, inject = 0;
    int          last_start = 0, exp_e = P + 1, pair_e = -1, cap = 0;
    int          conv_cnt = 0, pair_cnt = 0, q_starts = 0;
    int          chk_idx = 0;
    logic [11:0] chk_val, val;

    initial forever begin
        @(posedge clk);
        ecnt = rst_n ? ecnt + 1 : 0;
    end

    initial begin
        spi_done = 1'b0;
        spi_rd   = 16'h0000;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (!rst_n) begin
                busy = 0; rd_phase = 0; wr_in_conv = 0; exp_idx = 0;
                foreach (exp_res[i]) exp_res[i] = 12'h000;
                last_start = 0; exp_e = P + 1; wr_exp = 1;
                pair_e = -1; chk_pend = 0;
                continue;
            end
            if (inject) begin
                spi_done = 1'b1;
                spi_rd   = 16'hFFFF;
                inject   = 0;
            end
            if (chk_pend) begin
                check("result", get_res(chk_idx), chk_val);
                chk_pend = 0;
                conv_cnt++;
            end
            if (pair_vld || ecnt == pair_e) begin
                check("pair_vld_time", pair_vld && ecnt == pair_e, 1);
                if (pair_vld) begin
                    pair_cnt++;
                    check("flags", {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16},
                          flag_model(exp_res[0], exp_res[1]));
                end
                pair_e = -1;
            end
            if (spi_wrt || (wr_exp && ecnt == exp_e)) begin
                check("spi_wrt_time", spi_wrt && wr_exp && ecnt == exp_e, 1);
                if (spi_wrt) begin
                    check("spi_cmd", spi_cmd, cmd_word(exp_idx));
                    cmd_log.push_back(spi_cmd);
                    rd_phase = (wr_in_conv == 1);
                    if (!rd_phase) last_start = ecnt;
                    wr_in_conv++;
                    busy = 1;
                    cnt_down = lat;
                end
                wr_exp = 0;
            end else if (busy) begin
                cnt_down--;
                if (cnt_down == 0) begin
                    busy = 0;
                    spi_done = 1'b1;
                    wr_exp = 1;
                    if (rd_phase) begin
                        val = (data_q.size() > 0) ? data_q.pop_front() : 12'($urandom);
                        spi_rd = {4'($urandom), val};
                        exp_res[exp_idx] = val;
                        chk_pend = 1; chk_idx = exp_idx; chk_val = val;
                        if (exp_idx == 1) pair_e = ecnt + 2;
                        exp_idx = (exp_idx + 1) % 4;
                        wr_in_conv = 0;
                        // any tick since the last start queues an immediate restart
                        cap = ecnt + 1;
                        if (cap / P > last_start / P) begin
                            exp_e = cap + 1;
                            q_starts++;
                        end else begin
                            exp_e = (cap / P + 1) * P + 1;
                        end
                    end else begin
                        spi_rd = 16'($urandom);
                        exp_e = ecnt + 2;
                    end
                end
            end
        end
    end

    task automatic wait_conv(input int n, input int budget);
        int i = 0;
        while (conv_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("conv_timeout", conv_cnt >= n, 1);
    endtask

    task automatic wait_pair(input int n, input int budget);
        int i = 0;
        while (pair_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("pair_timeout", pair_cnt >= n, 1);
    endtask

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t        vt[9];
    logic [15:0] exp_cmds[8];
    int          sz;

    initial begin
        vt[0] = '{12'h100, 12'h100, 4'b0000};
        vt[1] = '{12'h140, 12'h140, 4'b1000};
        vt[2] = '{12'h0A0, 12'h0A0, 4'b0100};
        vt[3] = '{12'h300, 12'h100, 4'b1010};
        vt[4] = '{12'h3F0, 12'h000, 4'b1011};
        vt[5] = '{12'h120, 12'h120, 4'b0000};
        vt[6] = '{12'h0E0, 12'h0DF, 4'b0100};
        vt[7] = '{12'h0A0, 12'h060, 4'b0100};
        vt[8] = '{12'h0A1, 12'h060, 4'b0110};
        exp_cmds = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                     16'h2800, 16'h2800, 16'h3000, 16'h3000};

        clr_tmr = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spi_wrt", spi_wrt, 0);
        check("rst_spi_cmd", spi_cmd, 0);
        check("rst_pair_vld", pair_vld, 0);
        check("rst_lft", lft_ld, 0);
        check("rst_rght", rght_ld, 0);
        check("rst_steer", steer_pot, 0);
        check("rst_batt", batt, 0);
        check("rst_gt", sum_gt_min, 0);
        check("rst_lt", sum_lt_min, 1);
        check("rst_d14", diff_gt_1_4, 0);
        check("rst_d1516", diff_gt_15_16, 0);
        check("rst_tmr_full", tmr_full, 0);

        data_q.push_back(12'h123);
        data_q.push_back(12'h456);
        data_q.push_back(12'h789);
        data_q.push_back(12'hABC);
        #2 rst_n = 1'b1;
        wait_conv(4, 8 * P);
        check("lft_ld", lft_ld, 12'h123);
        check("rght_ld", rght_ld, 12'h456);
        check("steer_pot", steer_pot, 12'h789);
        check("batt", batt, 12'hABC);
        check("pair_once", pair_cnt, 1);
        check("cmd_count", cmd_log.size(), 8);
        if (cmd_log.size() >= 8)
            for (int i = 0; i < 8; i++)
                check("cmd_seq", cmd_log[i], exp_cmds[i]);

        for (int i = 0; i < 9; i++) begin
            data_q.push_back(vt[i].l);
            data_q.push_back(vt[i].r);
            data_q.push_back(12'($urandom));
            data_q.push_back(12'($urandom));
            wait_pair(pair_cnt + 1, 6 * P);
            check("flag_vec", {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16},
                  vt[i].f);
        end

        for (int i = 0; i < 24; i++) begin
            data_q.push_back(12'($urandom_range(0, 'h3FF)));
            data_q.push_back(12'($urandom_range(0, 'h3FF)));
            data_q.push_back(12'($urandom));
            data_q.push_back(12'($urandom));
            wait_pair(pair_cnt + 1, 6 * P);
        end

        lat = 3 * P;
        wait_conv(conv_cnt + 2, 20 * P);
        lat = 5;
        wait_conv(conv_cnt + 3, 8 * P);
        check("queued_start", q_starts > 0, 1);

        lat = 20;
        begin
            int i = 0;
            while (wr_in_conv != 2 && i < 8 * P) begin
                @(negedge clk);
                i++;
            end
            check("read_issue_timeout", wr_in_conv, 2);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_spi_wrt", spi_wrt, 0);
        check("midrst_lft", lft_ld, 0);
        check("midrst_rght", rght_ld, 0);
        check("midrst_steer", steer_pot, 0);
        check("midrst_batt", batt, 0);
        check("midrst_lt", sum_lt_min, 1);
        repeat (3) @(negedge clk);
        sz = cmd_log.size();
        #2 rst_n = 1'b1;
        inject = 1;
        lat = 5;
        repeat (3) @(negedge clk);
        check("late_done_lft", lft_ld, 0);
        check("late_done_wrt", spi_wrt, 0);
        wait_conv(conv_cnt + 1, 4 * P);
        check("restart_cmd_cnt", cmd_log.size() > sz, 1);
        if (cmd_log.size() > sz)
            check("restart_ch0", cmd_log[sz], 16'h0000);

`ifdef FAST_SIM_EN
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        begin
            int i = 0;
            while (ecnt < 32766 && i < 40000) begin
                @(negedge clk);
                i++;
            end
        end
        check("tmr_before_full", tmr_full, 0);
        @(negedge clk);
        check("tmr_full_rise", tmr_full, 1);
        repeat (5) @(negedge clk);
        check("tmr_full_hold", tmr_full, 1);
        #2 clr_tmr = 1'b1;
        @(negedge clk);
        #2 clr_tmr = 1'b0;
        check("tmr_clr", tmr_full, 0);
`else
        repeat (2000) @(negedge clk);
        check("tmr_not_full", tmr_full, 0);
        #2 clr_tmr = 1'b1;
        @(negedge clk);
        #2 clr_tmr = 1'b0;
        check("tmr_clr", tmr_full, 0);
`endif
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/steer_sense_sched.md
Name: steer_sense_sched

Overview:
- Round-robin scheduler that owns the shared SPI A2D master on the Segway board.
- Sequences conversions of four channels: left load cell, right load cell, steer pot, battery.
- Registers the results and derives the rider-presence/balance flags and the 1.3 s balance timer consumed by the steering-enable state machine.
- Sits between the SPI master and the steer-enable/balance control logic.

Parameters:
- PERIOD, 2048: clk cycles between successive channel conversion starts (≥ 64).
- MIN_RIDER_WT, 12'h200: minimum rider weight threshold (sum of load cells).
- HYST, 12'h040: hysteresis band applied around MIN_RIDER_WT.

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  async active-low reset
- spi_wrt  out  1  one-cycle pulse starting an SPI transaction
- spi_cmd  out  16  command word to SPI master
- spi_done  in  1  one-cycle pulse: transaction finished, spi_rd valid
- spi_rd  in  16  data returned by SPI master
- lft_ld, rght_ld, steer_pot, batt  out  12 each  latest conversion results
- pair_vld  out  1  one-cycle pulse, new left/right pair captured
- sum_gt_min, sum_lt_min  out  1  sum > MIN+HYST / sum < MIN−HYST
- diff_gt_1_4, diff_gt_15_16  out  1  |lft−rght| balance flags
- clr_tmr  in  1  synchronous clear of balance timer
- tmr_full  out  1  balance timer reached full count

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values:
  - all 12-bit results 0; spi_wrt 0; spi_cmd 0; pair_vld 0.
  - sum_lt_min 1; sum_gt_min, diff flags 0; tmr_full 0.
  - channel index 0; period counter 0; pending tick 0.
- Period counter is free-running 0..PERIOD−1. A tick is generated at PERIOD−1 and sets a one-deep pending flag; further ticks while pending are dropped.
- Channel order: idx 0 = ch0 → lft_ld, 1 = ch4 → rght_ld, 2 = ch5 → steer_pot, 3 = ch6 → batt. idx wraps 3 → 0.
- FSM:
  - IDLE: if pending → CMD, clear pending.
  - CMD: spi_wrt=1 for one cycle, spi_cmd = {2'b00, ch[2:0], 11'h000} → WAIT1.
  - WAIT1: hold until spi_done → GAP.
  - GAP: one idle cycle → READ.
  - READ: spi_wrt=1, spi_cmd = same channel word → WAIT2.
  - WAIT2: on spi_done capture spi_rd[11:0] into the result for idx, advance idx → IDLE.
- spi_cmd holds its value between writes. spi_wrt is never asserted outside CMD/READ. A spi_done arriving in IDLE/CMD/GAP/READ is ignored.
- Tick in the same cycle as the WAIT2 capture: pending is set, and the next conversion starts from IDLE on the following cycle.
- Flag update: pulse pair_vld the cycle after rght_ld capture. Flags are registered on that same cycle from the updated lft_ld/rght_ld.
  - sum = lft_ld + rght_ld, 13-bit unsigned.
  - diff = |lft_ld − rght_ld|, 12-bit.
  - sum_gt_min = sum > MIN_RIDER_WT+HYST; sum_lt_min = sum < MIN_RIDER_WT−HYST. Both 0 inside the band.
  - diff_gt_1_4 = diff > (sum>>2); diff_gt_15_16 = diff > sum − (sum>>4). All comparisons 13-bit unsigned.
  - Flags hold between updates.
- Timer: 26-bit up-counter. clr_tmr zeroes it, with priority over counting. It saturates at all-ones; tmr_full = counter all-ones (~1.34 s).
- Reset mid-transaction: FSM returns to IDLE and spi_wrt drops immediately. A late spi_done after reset is ignored.

Optional Feature:
- FAST_SIM_EN defined: timer is 15 bits (tmr_full after 32767 cycles) and the effective PERIOD is forced to 64, for fast full-chip simulation.
- Undefined: 26-bit timer; PERIOD as parameterised.

Test Plan:
- Reset then run 4 ticks, SPI model returns 12'h123, 12'h456, 12'h789, 12'hABC → spi_cmd sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000 (each sent twice); lft_ld=123, rght_ld=456, steer_pot=789, batt=ABC; pair_vld pulses once after rght capture.
- lft=12'h100, rght=12'h100 (sum 0x200, inside band) → sum_gt_min=0, sum_lt_min=0. Then lft=rght=12'h140 → sum_gt_min=1. Then lft=rght=12'h0A0 → sum_lt_min=1.
- lft=12'h300, rght=12'h100 (sum 0x400, diff 0x200) → diff_gt_1_4=1, diff_gt_15_16=0. lft=12'h3F0, rght=12'h000 → both 1.
- SPI model delays spi_done by 3×PERIOD → exactly one queued conversion follows, no extra spi_wrt pulses, idx order preserved.
- FAST_SIM_EN: hold clr_tmr low → tmr_full rises at cycle 32767 and stays high. Assert clr_tmr for one cycle → tmr_full=0 next cycle.
- Assert rst_n low during WAIT2 → spi_wrt=0, results unchanged at reset values, next conversion restarts at ch0.
